vga_text_renderer: RTL

//  Character-cell text renderer; sits directly downstream of the VGA timing generator.

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_delay_line.sv | 30 +++
 rtl/vga_text_renderer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg
// Shared cell geometry, pipeline depth and colour type for the text renderer.
// Revision: 1.0
// ============================================================================
package vga_pkg;
    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;
    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int LAT    = 5;

    typedef logic [11:0] rgb_t;

    localparam rgb_t FG_DEFAULT = 12'hFFF;
    localparam rgb_t BG_DEFAULT = 12'h00F;
endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// vga_delay_line
// Fixed-depth shift register with a per-bit reset value.
// Revision: 1.0
// ============================================================================
module vga_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 5,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/vga_text_renderer.sv
`default_nettype none
// ============================================================================
// vga_text_renderer
// Five-stage character-cell renderer: text RAM -> font ROM -> RGB with cursor.
// Revision: 1.0
// ============================================================================
module vga_text_renderer #(
    parameter int          X_SIZE     = 10,
    parameter int          Y_SIZE     = 10,
    parameter int          COLS       = 80,
    parameter int          ROWS       = 30,
    parameter int          CHAR_W     = 8,
    parameter int          CHAR_H     = 16,
    parameter int          ADDR_W     = 12,
    parameter int          BLINK_LOG2 = 4,
    parameter logic [11:0] FG_RGB     = 12'hFFF,
    parameter logic [11:0] BG_RGB     = 12'h00F
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         in_hsync,
    input  logic                         in_vsync,
    input  logic                         in_active,
    input  logic [X_SIZE-1:0]            in_x,
    input  logic [Y_SIZE-1:0]            in_y,
    input  logic                         cur_en,
    input  logic [6:0]                   cur_col,
    input  logic [4:0]                   cur_row,
    output logic [ADDR_W-1:0]            txt_addr,
    input  logic [7:0]                   txt_data,
    output logic [6+$clog2(CHAR_H):0]    font_addr,
    input  logic [CHAR_W-1:0]            font_data,
    output logic [11:0]                  rgb,
    output logic                         out_hsync,
    output logic                         out_vsync,
    output logic                         out_active
);
    import vga_pkg::*;

    localparam int XS_W    = $clog2(CHAR_W);
    localparam int YS_W    = $clog2(CHAR_H);
    localparam int CW      = X_SIZE - XS_W;
    localparam int RW      = Y_SIZE - YS_W;
    localparam int BLINK_W = BLINK_LOG2 + 1;

    logic [CW-1:0]      w_col;
    logic [RW-1:0]      w_row;
    logic [XS_W-1:0]    w_xsub;
    logic [YS_W-1:0]    w_ysub;
    logic               w_oob;
    logic               w_cur_hit;
    logic               w_pix;
    rgb_t               w_rgb;

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_vs_prev;

    logic [XS_W-1:0]    r_xsub1, r_xsub2, r_xsub3, r_xsub4;
    logic [YS_W-1:0]    r_ysub1, r_ysub2;
    logic               r_oob1, r_oob2, r_oob3, r_oob4;
    logic               r_cur1, r_cur2, r_cur3, r_cur4;
    logic               r_act1, r_act2, r_act3, r_act4;
    logic               r_inv3, r_inv4;

    assign w_col  = in_x[X_SIZE-1:XS_W];
    assign w_row  = in_y[Y_SIZE-1:YS_W];
    assign w_xsub = in_x[XS_W-1:0];
    assign w_ysub = in_y[YS_W-1:0];
    assign w_oob  = (w_col >= CW'(COLS)) || (w_row >= RW'(ROWS));

    // Blink phase is sampled together with the pixel so cursor visibility never splits a cell.
    assign w_cur_hit = cur_en & r_blink_cnt[BLINK_W-1]
                     & (w_col == CW'(cur_col)) & (w_row == RW'(cur_row))
                     & (w_ysub >= YS_W'(CHAR_H - 2));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_vs_prev   <= 1'b0;
            r_blink_cnt <= '0;
        end else begin
            r_vs_prev <= in_vsync;
            if (r_vs_prev && !in_vsync) r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            txt_addr  <= '0;
            font_addr <= '0;
            r_xsub1 <= '0; r_xsub2 <= '0; r_xsub3 <= '0; r_xsub4 <= '0;
            r_ysub1 <= '0; r_ysub2 <= '0;
            r_oob1  <= 1'b0; r_oob2 <= 1'b0; r_oob3 <= 1'b0; r_oob4 <= 1'b0;
            r_cur1  <= 1'b0; r_cur2 <= 1'b0; r_cur3 <= 1'b0; r_cur4 <= 1'b0;
            r_act1  <= 1'b0; r_act2 <= 1'b0; r_act3 <= 1'b0; r_act4 <= 1'b0;
            r_inv3  <= 1'b0; r_inv4 <= 1'b0;
        end else begin
            txt_addr <= ADDR_W'(w_row) * ADDR_W'(COLS) + ADDR_W'(w_col);
            r_xsub1  <= w_xsub;  r_ysub1 <= w_ysub;
            r_oob1   <= w_oob;   r_cur1  <= w_cur_hit; r_act1 <= in_active;

            r_xsub2  <= r_xsub1; r_ysub2 <= r_ysub1;
            r_oob2   <= r_oob1;  r_cur2  <= r_cur1;    r_act2 <= r_act1;

            font_addr <= {txt_data[6:0], r_ysub2};
            r_inv3    <= txt_data[7];
            r_xsub3   <= r_xsub2; r_oob3 <= r_oob2; r_cur3 <= r_cur2; r_act3 <= r_act2;

            r_inv4  <= r_inv3;
            r_xsub4 <= r_xsub3; r_oob4 <= r_oob3; r_cur4 <= r_cur3; r_act4 <= r_act3;
        end
    end

    always_comb begin
        w_pix = (font_data[XS_W'(CHAR_W - 1) - r_xsub4] ^ r_inv4) | r_cur4;
        w_rgb = '0;
        if (r_act4) begin
            if (r_oob4)     w_rgb = BG_RGB;
            else if (w_pix) w_rgb = FG_RGB;
            else            w_rgb = BG_RGB;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rgb <= '0;
        else        rgb <= w_rgb;
    end

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (LAT),
        .RST_VAL (3'b110)
    ) u_sync_dly (
        .clk   (CLK),
        .rst_n (RST_N),
        .i_d   ({in_hsync, in_vsync, in_active}),
        .o_q   ({out_hsync, out_vsync, out_active})
    );
endmodule
`default_nettype wire
